// File: rtl/fifo_rd_stream.sv
// Read-side stream adapter for an async FIFO: pops the registered FIFO memory and
// presents samples through a 3-entry skid buffer with valid/ready on the output.
module fifo_rd_stream #(
   parameter int DATA_WIDTH = 16
) (
   input  logic                  i_rd_clk,
   input  logic                  i_rdrst_n,
   input  logic                  i_rd_empty,
   output logic                  o_rd_inc,
   input  logic [DATA_WIDTH-1:0] i_rd_data,
   output logic                  o_valid,
   input  logic                  i_ready,
   output logic [DATA_WIDTH-1:0] o_data,
   output logic [1:0]            o_occ
);

   // Handshake: a sample transfers on a rising clock edge where o_valid and i_ready
   // are both 1; o_data holds steady while o_valid=1 and i_ready=0.

   logic [1:0]            occ_q, occ_d;
   logic                  infl_q, infl_d;
   logic [1:0]            wr_ptr_q, wr_ptr_d;
   logic [1:0]            rd_ptr_q, rd_ptr_d;
   logic [DATA_WIDTH-1:0] buf_q [3];
   logic [DATA_WIDTH-1:0] buf_d [3];
   logic [2:0]            fill;
   logic                  accept;

   function automatic logic [1:0] ptr_inc(input logic [1:0] p);
      return (p == 2'd2) ? 2'd0 : p + 2'd1;
   endfunction

   // The pop decision counts the in-flight word as already occupying a slot, so the
   // buffer can absorb it even when the consumer stalls; i_ready is never consulted.
   always_comb begin
      fill     = {1'b0, occ_q} + {2'b00, infl_q};
      o_rd_inc = i_rdrst_n & ~i_rd_empty & (fill <= 3'd2);
      o_valid  = (occ_q != 2'd0);
      o_data   = buf_q[rd_ptr_q];
      o_occ    = occ_q;
      accept   = o_valid & i_ready;

      infl_d   = o_rd_inc & ~i_rd_empty;
      buf_d    = buf_q;
      wr_ptr_d = wr_ptr_q;
      rd_ptr_d = rd_ptr_q;

      if (infl_q) begin
         buf_d[wr_ptr_q] = i_rd_data;
         wr_ptr_d        = ptr_inc(wr_ptr_q);
      end
      if (accept) begin
         rd_ptr_d = ptr_inc(rd_ptr_q);
      end
      occ_d = occ_q + {1'b0, infl_q} - {1'b0, accept};
   end

   always_ff @(posedge i_rd_clk) begin
      if (!i_rdrst_n) begin
         occ_q    <= 2'd0;
         infl_q   <= 1'b0;
         wr_ptr_q <= 2'd0;
         rd_ptr_q <= 2'd0;
         buf_q    <= '{default: '0};
      end else begin
         occ_q    <= occ_d;
         infl_q   <= infl_d;
         wr_ptr_q <= wr_ptr_d;
         rd_ptr_q <= rd_ptr_d;
         buf_q    <= buf_d;
      end
   end

   // Stored plus in-flight words must always fit in the three slots.
   a_no_overflow : assert property (@(posedge i_rd_clk) disable iff (!i_rdrst_n)
      fill <= 3'd3);

endmodule
